// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: the signals between the ID/EX control logic and the
// forwarding / load-use hazard unit.
// With FWD_HAZARD_STATS_EN defined the bundle also carries the two
// statistics counters, stall_cycles and fwd_events.
//
// Handshake contract: the ID stage offers an instruction whenever id_valid
// is high. The instruction is accepted into EX on a rising edge where
// hold=0, stall=0 and flush=0. While stall is high the ID stage must keep
// presenting the same instruction. flush discards the offered instruction
// without accepting it. hold freezes every stage, including the unit's slots.
interface fwd_hazard_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int FWD_W  = $clog2(DEPTH + 1)
);
  // ID stage instruction and pipeline control
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [ADDR_W-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              hold;

  // Results back to the EX operand muxes and the fetch/decode stages
  logic [FWD_W-1:0]  forward_a;
  logic [FWD_W-1:0]  forward_b;
  logic              stall;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       fwd_events;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
    output id_reg_write, id_mem_read, flush, hold,
    input  forward_a, forward_b, stall, stall_cycles, fwd_events
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
    input  id_reg_write, id_mem_read, flush, hold,
    output forward_a, forward_b, stall, stall_cycles, fwd_events
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
    output id_reg_write, id_mem_read, flush, hold,
    input  forward_a, forward_b, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
    input  id_reg_write, id_mem_read, flush, hold,
    output forward_a, forward_b, stall
  );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and load-use hazard unit for the pipelined
// MIPS core.
//
// The unit keeps a shadow copy of every instruction between EX and
// write-back. It holds these in slots 0..DEPTH. Slot 0 is the instruction
// now in EX, slot 1 is EX/MEM, slot 2 is MEM/WB, and so on.
// From the slots it produces:
//   - forward_a / forward_b: priority-encoded bypass selects for the EX
//     operands. 0 means the register file; k means the result held by slot k.
//     The youngest matching producer wins.
//   - stall: asserted while the ID instruction reads the destination of a
//     load that is still inside the first LOAD_LAT slots.
// A stall turns slot 0 into a bubble. The load then moves down the slots
// and the stall ends by itself, so the unit needs no stall counter.
//
// Optional feature: define FWD_HAZARD_STATS_EN to add two saturating
// counters, stall_cycles and fwd_events, to the interface.
//
// Legal parameter ranges: DEPTH 1..6, LOAD_LAT 1..DEPTH.
module fwd_hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int FWD_W    = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              reset,
  fwd_hazard_unit_if.slave bus
);

  // One shadow entry. Later slots keep rs/rt only to stay a copy of
  // slot 0; forwarding reads sources from slot 0 alone.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
  } slot_t;

  slot_t             slots [DEPTH+1];
  slot_t             id_slot;
  logic [DEPTH:0]    producer;
  logic [FWD_W-1:0]  fwd_a;
  logic [FWD_W-1:0]  fwd_b;
  logic              load_use;
  logic              stall_int;
  logic              capture;

  // A slot is a usable producer when it is a real instruction that writes
  // a register other than $0. Writes to $0 are discarded by the register
  // file, so they must never be forwarded.
  always_comb begin
    producer = '0;
    for (int k = 0; k <= DEPTH; k++) begin
      producer[k] = slots[k].valid & slots[k].reg_write &
                    (slots[k].rd != '0);
    end
  end

  // Operand A bypass: the loop walks from the oldest slot to the youngest,
  // so the last match, which is the smallest k, wins.
  always_comb begin
    fwd_a = '0;
    if (slots[0].valid) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (producer[k] && (slots[k].rd == slots[0].rs)) begin
          fwd_a = FWD_W'(k);
        end
      end
    end
  end

  // Operand B bypass: same priority as A, evaluated independently on rt
  always_comb begin
    fwd_b = '0;
    if (slots[0].valid) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (producer[k] && (slots[k].rd == slots[0].rt)) begin
          fwd_b = FWD_W'(k);
        end
      end
    end
  end

  // Load-use detection. A load in slot j < LOAD_LAT has not yet produced
  // forwardable data. The ID instruction must wait if it actually reads
  // that load's destination.
  always_comb begin
    load_use = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (producer[j] && slots[j].mem_read &&
          ((bus.id_uses_rs && (bus.id_rs == slots[j].rd)) ||
           (bus.id_uses_rt && (bus.id_rt == slots[j].rd)))) begin
        load_use = 1'b1;
      end
    end
  end

  // A flush kills the ID instruction, so it overrides any stall against it
  assign stall_int = load_use & bus.id_valid & ~bus.flush;
  assign capture   = bus.id_valid & ~stall_int & ~bus.flush;

  // Next contents of slot 0. A bubble is fully zeroed, which keeps the
  // shadow state easy to read in a waveform.
  always_comb begin
    id_slot = '0;
    if (capture) begin
      id_slot.valid     = 1'b1;
      id_slot.reg_write = bus.id_reg_write;
      id_slot.mem_read  = bus.id_mem_read;
      id_slot.rd        = bus.id_rd;
      id_slot.rs        = bus.id_rs;
      id_slot.rt        = bus.id_rt;
    end
  end

  // Slot pipeline. It advances on every edge that is not frozen by hold.
  // Reset discards all in-flight state at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= DEPTH; k++) begin
        slots[k] <= '0;
      end
    end else if (!bus.hold) begin
      for (int k = 1; k <= DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
      slots[0] <= id_slot;
    end
  end

  assign bus.forward_a = fwd_a;
  assign bus.forward_b = fwd_b;
  assign bus.stall     = stall_int;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;

  // Saturating counters of real stall cycles and of cycles that use a
  // bypass. Frozen cycles are not counted because nothing advances in them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!bus.hold) begin
      if (stall_int && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (((fwd_a != '0) || (fwd_b != '0)) && (fwd_cnt != 32'hFFFF_FFFF)) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.fwd_events   = fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed bench for fwd_hazard_unit.
// dut2 uses DEPTH=2, LOAD_LAT=1; dut3 uses DEPTH=3, LOAD_LAT=2.
// Each expected cycle entry packs {forward_a, forward_b, stall}.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  logic clk;
  logic rst2;
  logic rst3;

  int checks;
  int errors;

  logic [4:0] exp2_q [$];
  logic [4:0] exp3_q [$];
  string      name2_q [$];
  string      name3_q [$];

  fwd_hazard_unit_if #(.ADDR_W(5), .DEPTH(2)) bus2 ();
  fwd_hazard_unit_if #(.ADDR_W(5), .DEPTH(3)) bus3 ();

  fwd_hazard_unit #(.ADDR_W(5), .DEPTH(2), .LOAD_LAT(1)) u_dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2)
  );

  fwd_hazard_unit #(.ADDR_W(5), .DEPTH(3), .LOAD_LAT(2)) u_dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (bus3)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction builders
  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt);
    return '{v: 1'b1, rs: rs, rt: rt, urs: 1'b1, urt: 1'b1, rd: rd,
             rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic instr_t li(input logic [4:0] rd);
    return '{v: 1'b1, rs: 5'd0, rt: 5'd0, urs: 1'b0, urt: 1'b0, rd: rd,
             rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] base);
    return '{v: 1'b1, rs: base, rt: 5'd0, urs: 1'b1, urt: 1'b0, rd: rd,
             rw: 1'b1, mr: 1'b1};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic drive_id(input int dut, input instr_t i, input logic fl,
                          input logic hd);
    if (dut == 2) begin
      bus2.id_valid     = i.v;
      bus2.id_rs        = i.rs;
      bus2.id_rt        = i.rt;
      bus2.id_uses_rs   = i.urs;
      bus2.id_uses_rt   = i.urt;
      bus2.id_rd        = i.rd;
      bus2.id_reg_write = i.rw;
      bus2.id_mem_read  = i.mr;
      bus2.flush        = fl;
      bus2.hold         = hd;
    end else begin
      bus3.id_valid     = i.v;
      bus3.id_rs        = i.rs;
      bus3.id_rt        = i.rt;
      bus3.id_uses_rs   = i.urs;
      bus3.id_uses_rt   = i.urt;
      bus3.id_rd        = i.rd;
      bus3.id_reg_write = i.rw;
      bus3.id_mem_read  = i.mr;
      bus3.flush        = fl;
      bus3.hold         = hd;
    end
  endtask

  // Present one ID cycle, record what the outputs must be in it, advance.
  task automatic step(input int dut, input instr_t i, input logic fl,
                      input logic hd, input logic [1:0] efa,
                      input logic [1:0] efb, input logic est,
                      input string name);
    drive_id(dut, i, fl, hd);
    if (dut == 2) begin
      exp2_q.push_back({efa, efb, est});
      name2_q.push_back(name);
    end else begin
      exp3_q.push_back({efa, efb, est});
      name3_q.push_back(name);
    end
    @(posedge clk);
    #1;
  endtask

  // monitors
  logic [4:0] m2_e;
  string      m2_n;
  always @(negedge clk) begin
    if (exp2_q.size() > 0) begin
      m2_e = exp2_q.pop_front();
      m2_n = name2_q.pop_front();
      check({m2_n, ".fa"}, 32'(bus2.forward_a), 32'(m2_e[4:3]));
      check({m2_n, ".fb"}, 32'(bus2.forward_b), 32'(m2_e[2:1]));
      check({m2_n, ".stall"}, 32'(bus2.stall), 32'(m2_e[0]));
    end
  end

  logic [4:0] m3_e;
  string      m3_n;
  always @(negedge clk) begin
    if (exp3_q.size() > 0) begin
      m3_e = exp3_q.pop_front();
      m3_n = name3_q.pop_front();
      check({m3_n, ".fa"}, 32'(bus3.forward_a), 32'(m3_e[4:3]));
      check({m3_n, ".fb"}, 32'(bus3.forward_b), 32'(m3_e[2:1]));
      check({m3_n, ".stall"}, 32'(bus3.stall), 32'(m3_e[0]));
    end
  end

  // reset and stimulus
  initial begin
    checks = 0;
    errors = 0;
    rst2   = 1'b0;
    rst3   = 1'b0;
    // a would-be load consumer in ID while reset is held
    drive_id(2, alu(9, 8, 2), 1'b0, 1'b0);
    drive_id(3, alu(9, 8, 2), 1'b0, 1'b0);
    #12;
    check("rst2.fa", 32'(bus2.forward_a), 0);
    check("rst2.fb", 32'(bus2.forward_b), 0);
    check("rst2.stall", 32'(bus2.stall), 0);
    check("rst3.fa", 32'(bus3.forward_a), 0);
    check("rst3.stall", 32'(bus3.stall), 0);
`ifdef FWD_HAZARD_STATS_EN
    check("rst2.stall_cycles", bus2.stall_cycles, 0);
    check("rst2.fwd_events", bus2.fwd_events, 0);
`endif
    drive_id(3, nop(), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst2 = 1'b1;
    rst3 = 1'b1;

    // back-to-back ALU
    step(2, alu(3, 1, 2), 0, 0, 0, 0, 0, "b2b_add");
    step(2, alu(4, 3, 3), 0, 0, 0, 0, 0, "b2b_sub_id");
    step(2, nop(),        0, 0, 1, 1, 0, "b2b_sub_ex");
    step(2, nop(),        0, 0, 0, 0, 0, "b2b_drain");
    // dual source, different ages
    step(2, li(5),        0, 0, 0, 0, 0, "dual_w5");
    step(2, li(6),        0, 0, 0, 0, 0, "dual_w6");
    step(2, alu(20, 5, 6), 0, 0, 0, 0, 0, "dual_use_id");
    step(2, nop(),        0, 0, 2, 1, 0, "dual_use_ex");
    step(2, nop(),        0, 0, 0, 0, 0, "dual_drain");
    // youngest wins, then $0 is never forwarded
    step(2, li(7),        0, 0, 0, 0, 0, "young_w7a");
    step(2, li(7),        0, 0, 0, 0, 0, "young_w7b");
    step(2, alu(21, 7, 0), 0, 0, 0, 0, 0, "young_use_id");
    step(2, alu(0, 0, 0), 0, 0, 1, 0, 0, "young_use_ex");
    step(2, alu(22, 0, 0), 0, 0, 0, 0, 0, "zero_w0_ex");
    step(2, nop(),        0, 0, 0, 0, 0, "zero_use_ex");
    step(2, nop(),        0, 0, 0, 0, 0, "zero_drain");
    // load-use, one stall cycle
    step(2, ld(8, 1),     0, 0, 0, 0, 0, "lu_lw");
    step(2, alu(9, 8, 2), 0, 0, 0, 0, 1, "lu_stall");
    step(2, alu(9, 8, 2), 0, 0, 0, 0, 0, "lu_release");
    step(2, nop(),        0, 0, 2, 0, 0, "lu_fwd");
    step(2, nop(),        0, 0, 0, 0, 0, "lu_drain");
    // flush during a load-use hazard
    step(2, ld(8, 1),     0, 0, 0, 0, 0, "fl_lw");
    step(2, alu(9, 8, 2), 1, 0, 0, 0, 0, "fl_flush");
    step(2, nop(),        0, 0, 0, 0, 0, "fl_bubble");
    // unused source field does not stall, yet still selects a bypass
    step(2, ld(8, 1),     0, 0, 0, 0, 0, "nouse_lw");
    step(2, '{v: 1'b1, rs: 5'd1, rt: 5'd8, urs: 1'b1, urt: 1'b0, rd: 5'd15,
              rw: 1'b1, mr: 1'b0}, 0, 0, 0, 0, 0, "nouse_id");
    step(2, nop(),        0, 0, 0, 1, 0, "nouse_ex");
    step(2, nop(),        0, 0, 0, 0, 0, "nouse_drain");
    // hold freezes the slots for three cycles
    step(2, li(11),        0, 0, 0, 0, 0, "hold_w11");
    step(2, alu(12, 11, 11), 0, 0, 0, 0, 0, "hold_use_id");
    step(2, alu(13, 1, 2), 0, 1, 1, 1, 0, "hold_c1");
    step(2, alu(13, 1, 2), 0, 1, 1, 1, 0, "hold_c2");
    step(2, alu(13, 1, 2), 0, 1, 1, 1, 0, "hold_c3");
    step(2, alu(13, 1, 2), 0, 0, 1, 1, 0, "hold_release");
    step(2, nop(),         0, 0, 0, 0, 0, "hold_next_ex");
    step(2, nop(),         0, 0, 0, 0, 0, "hold_drain");
`ifdef FWD_HAZARD_STATS_EN
    check("pre_rst.stall_cycles", bus2.stall_cycles, 1);
    check("pre_rst.fwd_events", bus2.fwd_events, 6);
`endif
    // reset asserted in the middle of a stall cycle
    step(2, ld(8, 1), 0, 0, 0, 0, 0, "mrst_lw");
    drive_id(2, alu(9, 8, 2), 1'b0, 1'b0);
    exp2_q.push_back({2'd0, 2'd0, 1'b1});
    name2_q.push_back("mrst_stall");
    @(negedge clk);
    #1;
    rst2 = 1'b0;
    #1;
    check("mrst.stall", 32'(bus2.stall), 0);
    check("mrst.fa", 32'(bus2.forward_a), 0);
    check("mrst.fb", 32'(bus2.forward_b), 0);
`ifdef FWD_HAZARD_STATS_EN
    check("mrst.stall_cycles", bus2.stall_cycles, 0);
    check("mrst.fwd_events", bus2.fwd_events, 0);
`endif
    @(posedge clk);
    #1;
    rst2 = 1'b1;
    step(2, ld(8, 1),     0, 0, 0, 0, 0, "post_lw");
    step(2, alu(9, 8, 2), 0, 0, 0, 0, 1, "post_stall");
    step(2, alu(9, 8, 2), 0, 0, 0, 0, 0, "post_release");
    step(2, nop(),        0, 0, 2, 0, 0, "post_fwd");
    step(2, nop(),        0, 0, 0, 0, 0, "post_drain");
`ifdef FWD_HAZARD_STATS_EN
    check("post.stall_cycles", bus2.stall_cycles, 1);
    check("post.fwd_events", bus2.fwd_events, 1);
`endif
    drive_id(2, nop(), 1'b0, 1'b0);

    // DEPTH=3, LOAD_LAT=2: two stall cycles for an adjacent consumer
    step(3, ld(8, 1),     0, 0, 0, 0, 0, "d3_lw");
    step(3, alu(9, 8, 2), 0, 0, 0, 0, 1, "d3_stall1");
    step(3, alu(9, 8, 2), 0, 0, 0, 0, 1, "d3_stall2");
    step(3, alu(9, 8, 2), 0, 0, 0, 0, 0, "d3_release");
    step(3, nop(),        0, 0, 3, 0, 0, "d3_fwd");
    step(3, nop(),        0, 0, 0, 0, 0, "d3_drain");
    // one independent instruction between load and consumer: one stall
    step(3, ld(9, 1),      0, 0, 0, 0, 0, "d3_gap_lw");
    step(3, alu(14, 1, 2), 0, 0, 0, 0, 0, "d3_gap_or");
    step(3, alu(10, 9, 2), 0, 0, 0, 0, 1, "d3_gap_stall");
    step(3, alu(10, 9, 2), 0, 0, 0, 0, 0, "d3_gap_release");
    step(3, nop(),         0, 0, 3, 0, 0, "d3_gap_fwd");
    step(3, nop(),         0, 0, 0, 0, 0, "d3_gap_drain");
`ifdef FWD_HAZARD_STATS_EN
    check("d3.stall_cycles", bus3.stall_cycles, 3);
    check("d3.fwd_events", bus3.fwd_events, 2);
`endif

    // report
    @(negedge clk);
    #1;
    check("queues_drained", 32'(exp2_q.size() + exp3_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
